// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and helpers for the round-robin stream mux
package stream_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width that never collapses to zero bits for degenerate channel counts.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate/find-first/rotate-back arbiter with one-hot grant
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = ARB_RR,
  localparam int CW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] idx
);

  logic [N-1:0] rot;
  int           base;
  int           hit;
  int           j;

  always_comb begin
    rot   = '0;
    grant = '0;
    idx   = '0;
    base  = 0;
    hit   = N;
    j     = 0;
    // Fixed-priority mode is round-robin frozen at base 0.
    if (RR == ARB_RR && int'(ptr) < N) base = int'(ptr);
    for (int k = 0; k < N; k++) begin
      j = base + k;
      if (j >= N) j = j - N;
      rot[k] = req[CW'(j)];
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) hit = k;
    end
    if (en && hit < N) begin
      j = base + hit;
      if (j >= N) j = j - N;
      idx        = CW'(j);
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux with arbitrated registered output
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 4,
  parameter int RR   = ARB_RR,
  localparam int CW  = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [CW-1:0]     out_ch
);

  logic [CW-1:0]   ptr;
  logic [CW-1:0]   idx;
  logic [N_CH-1:0] grant;
  logic            load;
  logic            xfer;

  // Register can accept whenever it is empty or being drained this cycle.
  assign load = ~out_valid | out_ready;

  rr_arbiter #(
    .N  (N_CH),
    .RR (RR)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .en    (load & ~rst),
    .grant (grant),
    .idx   (idx)
  );

  assign in_ready = grant;
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(idx)*W +: W];
        out_ch    <= idx;
        if (RR == ARB_RR) ptr <= (idx == CW'(N_CH - 1)) ? '0 : idx + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
